mist_frame_tracker: RTL and testbench

Simulation-side frame tracker feeding the dump controller. Synchronises the video vertical sync and the ROM-download indicator into the testbench clock, maintains the 32-bit frame counter, and generates the dump-window and end-of-simulation controls. Its frame_cnt and dump_en outputs drive the dump controller's trigger inputs; sim_done drives the testbench finish logic.

---
 rtl/mist_frame_pkg.sv | 19 +
 rtl/mist_sync_edge.sv | 34 +++
 rtl/mist_frame_tracker.sv | 148 ++++++++++++++
 tb/tb_mist_frame_tracker.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mist_frame_pkg.sv
// rtl/mist_frame_pkg.sv - shared types and constants for the frame tracker
package mist_frame_pkg;

    localparam int FRAME_W = 32;
    localparam logic [FRAME_W-1:0] FRAME_MAX = '1;

    typedef enum logic [1:0] {
        ST_WAIT_DL = 2'd0,
        ST_COUNT   = 2'd1,
        ST_DUMP    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Frame counter increment that sticks at the top value instead of wrapping.
    function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
        return (v == FRAME_MAX) ? v : v + FRAME_W'(1);
    endfunction

endpackage

// File: rtl/mist_sync_edge.sv
// rtl/mist_sync_edge.sv - two-flop synchroniser with edge detection
module mist_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic hist_q;

    // Two synchroniser stages plus one history stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= RESET_VAL;
            sync_q <= RESET_VAL;
            hist_q <= RESET_VAL;
        end else begin
            meta   <= din;
            sync_q <= meta;
            hist_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = ~hist_q & sync_q;
    assign fall  = hist_q & ~sync_q;

endmodule

// File: rtl/mist_frame_tracker.sv
// rtl/mist_frame_tracker.sv - frame counter and dump-window control
module mist_frame_tracker
    import mist_frame_pkg::*;
#(
    parameter bit          WAIT_DL    = 1'b1,
    parameter int unsigned DUMP_START = 0,
    parameter int unsigned DUMP_LEN   = 0,
    parameter int unsigned MAX_FRAMES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs,
    input  logic               downloading,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               vs_fall,
    output logic               dump_en,
    output logic               dump_start,
    output logic               dump_stop,
    output logic               sim_done,
    output logic               finished
);

    localparam logic [FRAME_W-1:0] START_V = FRAME_W'(DUMP_START);
    localparam logic [FRAME_W-1:0] LEN_V   = FRAME_W'(DUMP_LEN);
    localparam logic [FRAME_W-1:0] MAX_V   = FRAME_W'(MAX_FRAMES);
    localparam state_t             INIT_ST = WAIT_DL ? ST_WAIT_DL : ST_COUNT;

    logic vs_level, vs_rise, vs_edge;
    logic dl_level, dl_rise, dl_end;
    logic unused_sync;

    state_t             state, state_n;
    logic [FRAME_W-1:0] win, win_n;
    logic [FRAME_W-1:0] cnt_n;
    logic               fall_n, en_n, start_n, stop_n, done_n, fin_n;

    // vs idles high, so its synchroniser resets to 1 to avoid a false edge.
    mist_sync_edge #(.RESET_VAL(1'b1)) u_vs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (vs),
        .level (vs_level),
        .rise  (vs_rise),
        .fall  (vs_edge)
    );

    mist_sync_edge #(.RESET_VAL(1'b0)) u_dl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (downloading),
        .level (dl_level),
        .rise  (dl_rise),
        .fall  (dl_end)
    );

    assign unused_sync = &{1'b0, vs_level, vs_rise, dl_level};

    // Next-state and next-output logic; every event is tested with a plain
    // if so an unknown edge falls through to "no event" and never reaches
    // frame_cnt.
    always_comb begin
        state_n = state;
        win_n   = win;
        cnt_n   = frame_cnt;
        fall_n  = 1'b0;
        en_n    = dump_en;
        start_n = 1'b0;
        stop_n  = 1'b0;
        done_n  = 1'b0;
        fin_n   = finished;
        case (state)
            ST_WAIT_DL: begin
                if (dl_end) begin
                    state_n = ST_COUNT;
                    cnt_n   = '0;
                end
            end
            ST_COUNT, ST_DUMP: begin
                if (dl_rise) begin
                    // A new download invalidates the run: close the window
                    // and hold the count until the download finishes.
                    state_n = ST_WAIT_DL;
                    en_n    = 1'b0;
                    stop_n  = dump_en;
                end else if (vs_edge) begin
                    fall_n = 1'b1;
                    cnt_n  = sat_inc(frame_cnt);
                    if ((MAX_V != '0) && (cnt_n == MAX_V)) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        fin_n   = 1'b1;
                        en_n    = 1'b0;
                        stop_n  = dump_en;
                    end else if (state == ST_COUNT) begin
                        if (frame_cnt == START_V) begin
                            start_n = 1'b1;
                            win_n   = '0;
                            if (LEN_V == FRAME_W'(1)) begin
                                stop_n = 1'b1;
                            end else begin
                                en_n    = 1'b1;
                                state_n = ST_DUMP;
                            end
                        end
                    end else if ((LEN_V != '0) && (win == LEN_V - FRAME_W'(1))) begin
                        stop_n  = 1'b1;
                        en_n    = 1'b0;
                        state_n = ST_COUNT;
                    end else begin
                        win_n = win + FRAME_W'(1);
                    end
                end
            end
            ST_DONE: begin
                en_n = 1'b0;
            end
            default: begin
                state_n = INIT_ST;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT_ST;
            win        <= '0;
            frame_cnt  <= '0;
            vs_fall    <= 1'b0;
            dump_en    <= 1'b0;
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
            sim_done   <= 1'b0;
            finished   <= 1'b0;
        end else begin
            state      <= state_n;
            win        <= win_n;
            frame_cnt  <= cnt_n;
            vs_fall    <= fall_n;
            dump_en    <= en_n;
            dump_start <= start_n;
            dump_stop  <= stop_n;
            sim_done   <= done_n;
            finished   <= fin_n;
        end
    end

endmodule

// File: tb/tb_mist_frame_tracker.sv
// tb/tb_mist_frame_tracker.sv - self-checking bench for mist_frame_tracker
module tb_mist_frame_tracker;

    logic clk;
    logic rst [3];
    logic vs  [3];
    logic dl  [3];
    logic [31:0] fc [3];
    logic vf [3], den [3], dsa [3], dso [3], sd [3], fin [3];

    bit          P_WAIT  [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] P_START [3] = '{32'd2, 32'd1, 32'd0};
    logic [31:0] P_LEN   [3] = '{32'd3, 32'd0, 32'd1};
    logic [31:0] P_MAX   [3] = '{32'd0, 32'd4, 32'd0};

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mist_frame_tracker #(.WAIT_DL(1'b1), .DUMP_START(2), .DUMP_LEN(3), .MAX_FRAMES(0)) u_a (
        .clk(clk), .rst(rst[0]), .vs(vs[0]), .downloading(dl[0]), .frame_cnt(fc[0]),
        .vs_fall(vf[0]), .dump_en(den[0]), .dump_start(dsa[0]), .dump_stop(dso[0]),
        .sim_done(sd[0]), .finished(fin[0]));
    mist_frame_tracker #(.WAIT_DL(1'b0), .DUMP_START(1), .DUMP_LEN(0), .MAX_FRAMES(4)) u_b (
        .clk(clk), .rst(rst[1]), .vs(vs[1]), .downloading(dl[1]), .frame_cnt(fc[1]),
        .vs_fall(vf[1]), .dump_en(den[1]), .dump_start(dsa[1]), .dump_stop(dso[1]),
        .sim_done(sd[1]), .finished(fin[1]));
    mist_frame_tracker #(.WAIT_DL(1'b0), .DUMP_START(0), .DUMP_LEN(1), .MAX_FRAMES(0)) u_c (
        .clk(clk), .rst(rst[2]), .vs(vs[2]), .downloading(dl[2]), .frame_cnt(fc[2]),
        .vs_fall(vf[2]), .dump_en(den[2]), .dump_start(dsa[2]), .dump_stop(dso[2]),
        .sim_done(sd[2]), .finished(fin[2]));

    // Reference model: input samples are delayed so a level seen low at edge
    // k becomes a frame event at edge k+2; frames are then applied with the
    // run / window / done rules expressed as "frames seen inside the window".
    int          m_mode [3];
    logic [31:0] m_cnt  [3];
    int          m_wf   [3];
    bit m_en [3], m_vf [3], m_sa [3], m_so [3], m_sd [3], m_fin [3];
    bit v1 [3], v2 [3], v3 [3], d1 [3], d2 [3], d3 [3];

    // Reference model update (mode 0 waiting, 1 counting, 2 window, 3 done).
    always @(posedge clk) begin
        bit f, r, e;
        logic [31:0] pre;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_mode[i] = P_WAIT[i] ? 0 : 1;
                m_cnt[i] = 0; m_wf[i] = 0;
                m_en[i] = 0; m_vf[i] = 0; m_sa[i] = 0; m_so[i] = 0; m_sd[i] = 0; m_fin[i] = 0;
                v1[i] = 1; v2[i] = 1; v3[i] = 1; d1[i] = 0; d2[i] = 0; d3[i] = 0;
            end else begin
                f = v3[i] & ~v2[i];
                r = ~d3[i] & d2[i];
                e = d3[i] & ~d2[i];
                v3[i] = v2[i]; v2[i] = v1[i]; v1[i] = (vs[i] === 1'b0) ? 1'b0 : 1'b1;
                d3[i] = d2[i]; d2[i] = d1[i]; d1[i] = (dl[i] === 1'b1);
                m_vf[i] = 0; m_sa[i] = 0; m_so[i] = 0; m_sd[i] = 0;
                if (m_mode[i] == 0) begin
                    if (e) begin m_mode[i] = 1; m_cnt[i] = 0; end
                end else if (m_mode[i] == 1 || m_mode[i] == 2) begin
                    if (r) begin
                        m_so[i] = m_en[i]; m_en[i] = 0; m_mode[i] = 0;
                    end else if (f) begin
                        pre = m_cnt[i];
                        if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
                        m_vf[i] = 1;
                        if (P_MAX[i] != 0 && m_cnt[i] == P_MAX[i]) begin
                            m_sd[i] = 1; m_fin[i] = 1; m_so[i] = m_en[i]; m_en[i] = 0; m_mode[i] = 3;
                        end else if (m_mode[i] == 1 && pre == P_START[i]) begin
                            m_sa[i] = 1; m_wf[i] = 1;
                            if (P_LEN[i] == 1) m_so[i] = 1;
                            else begin m_en[i] = 1; m_mode[i] = 2; end
                        end else if (m_mode[i] == 2) begin
                            m_wf[i] = m_wf[i] + 1;
                            if (P_LEN[i] != 0 && m_wf[i] > int'(P_LEN[i])) begin
                                m_so[i] = 1; m_en[i] = 0; m_mode[i] = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Pulse bookkeeping used by the scenario summaries.
    int n_start [3], n_stop [3], n_done [3], n_both [3], n_done_stop [3];
    logic [31:0] stop_frame [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                n_start[i] = 0; n_stop[i] = 0; n_done[i] = 0; n_both[i] = 0; n_done_stop[i] = 0;
                stop_frame[i] = 0;
            end else begin
                if (dsa[i]) n_start[i]++;
                if (dso[i]) begin n_stop[i]++; stop_frame[i] = fc[i]; end
                if (sd[i]) n_done[i]++;
                if (dsa[i] && dso[i]) n_both[i]++;
                if (sd[i] && dso[i]) n_done_stop[i]++;
            end
        end
    end

    function automatic logic [37:0] obs(input int i);
        return {fc[i], vf[i], den[i], dsa[i], dso[i], sd[i], fin[i]};
    endfunction

    function automatic logic [37:0] expv(input int i);
        return {m_cnt[i], m_vf[i], m_en[i], m_sa[i], m_so[i], m_sd[i], m_fin[i]};
    endfunction

    bit vs_q [3][$];

    task automatic add_pulses(input int i, input int n);
        for (int p = 0; p < n; p++) begin
            repeat ($urandom_range(1, 2)) vs_q[i].push_back(1'b0);
            repeat ($urandom_range(3, 5)) vs_q[i].push_back(1'b1);
        end
    endtask

    task automatic drive_next();
        for (int i = 0; i < 3; i++) vs[i] = (vs_q[i].size() > 0) ? vs_q[i].pop_front() : 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin rst[i] = 1; vs[i] = 1; dl[i] = 0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs(i) !== 38'h0) begin n_fail++; $display("FAIL reset inst %0d: actual %h required 0", i, obs(i)); end
        end
        for (int i = 0; i < 3; i++) rst[i] = 0;
    endtask

    task automatic test_wait_download();
        int n;
        dl[0] = 1;
        add_pulses(0, 3);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0) || fc[0] !== 32'd0 || vf[0] !== 1'b0) begin
                n_fail++; $display("FAIL dl_hold cyc %0d: actual %h required %h", c, obs(0), expv(0));
            end
            drive_next();
        end
        dl[0] = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL dl_end cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        vs[0] = 0;
        @(negedge clk);
        n_checks++;
        if (vf[0] !== 1'b0 || fc[0] !== 32'd0) begin n_fail++; $display("FAIL latency_k: actual vf=%b cnt=%0d required vf=0 cnt=0", vf[0], fc[0]); end
        vs[0] = 1;
        @(negedge clk);
        n_checks++;
        if (vf[0] !== 1'b0 || fc[0] !== 32'd0) begin n_fail++; $display("FAIL latency_k1: actual vf=%b cnt=%0d required vf=0 cnt=0", vf[0], fc[0]); end
        @(negedge clk);
        n_checks++;
        if (vf[0] !== 1'b1 || fc[0] !== 32'd1) begin n_fail++; $display("FAIL latency_k2: actual vf=%b cnt=%0d required vf=1 cnt=1", vf[0], fc[0]); end
        add_pulses(0, 4);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL count cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        n_checks++;
        if (fc[0] !== 32'd5) begin n_fail++; $display("FAIL count_5: actual %0d required 5", fc[0]); end
    endtask

    task automatic test_dump_window();
        int n;
        add_pulses(0, 3);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL window cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        #1;
        n_checks++;
        if (n_start[0] !== 1 || n_stop[0] !== 1 || stop_frame[0] !== 32'd6 || fc[0] !== 32'd8 || den[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL window_summary: actual starts=%0d stops=%0d stop_at=%0d cnt=%0d en=%b required 1 1 6 8 0",
                     n_start[0], n_stop[0], stop_frame[0], fc[0], den[0]);
        end
    endtask

    task automatic test_max_frames();
        int n;
        add_pulses(1, 4);
        n = vs_q[1].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(1) !== expv(1)) begin n_fail++; $display("FAIL max cyc %0d: actual %h required %h", c, obs(1), expv(1)); end
            drive_next();
        end
        #1;
        n_checks++;
        if (fc[1] !== 32'd4 || fin[1] !== 1'b1 || n_done[1] !== 1 || n_done_stop[1] !== 1 || n_start[1] !== 1 || den[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL max_summary: actual cnt=%0d fin=%b done=%0d done_stop=%0d starts=%0d en=%b required 4 1 1 1 1 0",
                     fc[1], fin[1], n_done[1], n_done_stop[1], n_start[1], den[1]);
        end
        add_pulses(1, 3);
        n = vs_q[1].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(1) !== expv(1) || fc[1] !== 32'd4 || vf[1] !== 1'b0) begin
                n_fail++; $display("FAIL frozen cyc %0d: actual %h required %h", c, obs(1), expv(1));
            end
            drive_next();
        end
        #1;
        n_checks++;
        if (n_done[1] !== 1 || fin[1] !== 1'b1) begin n_fail++; $display("FAIL frozen_done: actual done=%0d fin=%b required 1 1", n_done[1], fin[1]); end
    endtask

    task automatic test_coincident();
        int n;
        add_pulses(2, 4);
        n = vs_q[2].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(2) !== expv(2) || den[2] !== 1'b0) begin
                n_fail++; $display("FAIL len1 cyc %0d: actual %h required %h", c, obs(2), expv(2));
            end
            drive_next();
        end
        #1;
        n_checks++;
        if (n_start[2] !== 1 || n_stop[2] !== 1 || n_both[2] !== 1 || fc[2] !== 32'd4) begin
            n_fail++;
            $display("FAIL len1_summary: actual starts=%0d stops=%0d together=%0d cnt=%0d required 1 1 1 4",
                     n_start[2], n_stop[2], n_both[2], fc[2]);
        end
    endtask

    task automatic restart_inst0();
        int n;
        @(negedge clk); rst[0] = 1;
        @(negedge clk);
        @(negedge clk); rst[0] = 0;
        dl[0] = 1;
        repeat (4) @(negedge clk);
        dl[0] = 0;
        repeat (6) @(negedge clk);
        add_pulses(0, 3);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL restart cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        n_checks++;
        if (fc[0] !== 32'd3 || den[0] !== 1'b1) begin n_fail++; $display("FAIL restart_open: actual cnt=%0d en=%b required 3 1", fc[0], den[0]); end
    endtask

    task automatic test_download_reassert();
        int n;
        restart_inst0();
        dl[0] = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL reassert cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        #1;
        n_checks++;
        if (n_stop[0] !== 1 || stop_frame[0] !== 32'd3 || den[0] !== 1'b0 || fc[0] !== 32'd3) begin
            n_fail++;
            $display("FAIL reassert_close: actual stops=%0d stop_at=%0d en=%b cnt=%0d required 1 3 0 3",
                     n_stop[0], stop_frame[0], den[0], fc[0]);
        end
        add_pulses(0, 2);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0) || fc[0] !== 32'd3) begin n_fail++; $display("FAIL reassert_hold cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        dl[0] = 0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (fc[0] !== 32'd0) begin n_fail++; $display("FAIL reassert_clear: actual %0d required 0", fc[0]); end
        add_pulses(0, 2);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0)) begin n_fail++; $display("FAIL resume cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        n_checks++;
        if (fc[0] !== 32'd2) begin n_fail++; $display("FAIL resume_cnt: actual %0d required 2", fc[0]); end
    endtask

    task automatic test_async_reset();
        int n;
        restart_inst0();
        @(negedge clk);
        #2 rst[0] = 1;
        #1;
        n_checks++;
        if (obs(0) !== 38'h0) begin n_fail++; $display("FAIL async_reset: actual %h required 0", obs(0)); end
        @(negedge clk);
        @(negedge clk); rst[0] = 0;
        add_pulses(0, 2);
        n = vs_q[0].size() + 6;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs(0) !== expv(0) || fc[0] !== 32'd0) begin n_fail++; $display("FAIL post_reset cyc %0d: actual %h required %h", c, obs(0), expv(0)); end
            drive_next();
        end
        restart_inst0();
    endtask

    task automatic test_random();
        int hold [3];
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL random inst %0d cyc %0d: actual %h required %h", i, c, obs(i), expv(i)); end
            end
            for (int i = 0; i < 3; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) rst[i] = 0;
                end else if ($urandom_range(0, 399) == 0) begin
                    rst[i] = 1; hold[i] = 2;
                end
                vs[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 59) == 0) dl[i] = ~dl[i];
            end
        end
        for (int i = 0; i < 3; i++) rst[i] = 0;
    endtask

    initial begin
        test_reset();
        test_wait_download();
        test_dump_window();
        test_max_frames();
        test_coincident();
        test_download_reassert();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
